// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: period/high-time registers reloaded only at
// period boundaries (or while idle), with a start-of-period tick strobe.
module clk_div_prog #(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] DEFAULT_DIV  = 16'd5999,
  parameter logic [WIDTH-1:0] DEFAULT_HIGH = 16'd3000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
  input  logic             load,
  output logic             load_ack,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_DIV  = (DEFAULT_DIV == '0) ? ONE : DEFAULT_DIV;
  localparam logic [WIDTH-1:0] RST_HIGH = (DEFAULT_HIGH == '0)     ? ONE :
                                          (DEFAULT_HIGH > RST_DIV) ? RST_DIV : DEFAULT_HIGH;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, r_div_act, r_high_act, r_pdiv, r_phigh;
  logic             r_pending, r_clk, r_tick, r_ack;

  logic [WIDTH-1:0] w_div_cl, w_high_cl, w_div_new, w_high_new, w_cnt_nxt;
  logic             w_wrap, w_apply, w_clk_nxt, w_tick_nxt;

  // State register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: en alone decides between running and idle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en)  w_state_nxt = S_RUN;
      S_RUN:   if (!en) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // high > div is the overflow-free form of high >= div+1
  always_comb begin
    w_div_cl  = (r_pdiv == '0) ? ONE : r_pdiv;
    w_high_cl = (r_phigh == '0)      ? ONE :
                (r_phigh > w_div_cl) ? w_div_cl : r_phigh;
  end

  always_comb begin
    w_wrap     = (r_cnt == r_div_act);
    w_apply    = r_pending && ((r_state == S_IDLE) || (en && w_wrap));
    w_div_new  = w_apply ? w_div_cl  : r_div_act;
    w_high_new = w_apply ? w_high_cl : r_high_act;
    w_cnt_nxt  = '0;
    w_clk_nxt  = 1'b0;
    w_tick_nxt = 1'b0;
    if (en) begin
      if (r_state == S_RUN) begin
        w_cnt_nxt  = w_wrap ? '0 : r_cnt + ONE;
        w_clk_nxt  = (w_cnt_nxt < w_high_new);
        w_tick_nxt = w_wrap;
      end else begin
        w_clk_nxt  = 1'b1;
        w_tick_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_clk      <= 1'b0;
      r_tick     <= 1'b0;
      r_ack      <= 1'b0;
      r_pending  <= 1'b0;
      r_pdiv     <= '0;
      r_phigh    <= '0;
      r_div_act  <= RST_DIV;
      r_high_act <= RST_HIGH;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_clk      <= w_clk_nxt;
      r_tick     <= w_tick_nxt;
      r_ack      <= w_apply;
      r_div_act  <= w_div_new;
      r_high_act <= w_high_new;
      // A load on the apply edge is kept for the following boundary
      r_pending  <= load | (r_pending & ~w_apply);
      if (load) begin
        r_pdiv  <= div_in;
        r_phigh <= high_in;
      end
    end
  end

  // Outputs straight from registers
  always_comb begin
    clk_out  = r_clk;
    tick     = r_tick;
    load_ack = r_ack;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable clock divider and strobe generator.
- Successor to the fixed-ratio divider: parametrised counter width, runtime period and duty cycle, enable gating, and glitch-free reload at period boundaries.
- `clk_out` is a registered fabric clock-enable/divided clock; `tick` is a one-cycle strobe that marks each period start.
- Drives ADC/codec sample strobes and SPI/LED timing in the SDR fabric.

Parameters:
- WIDTH, 16, width of the period and high-time counters.
- DEFAULT_DIV, 16'd5999, period minus one loaded at reset (period = DEFAULT_DIV+1 cycles).
- DEFAULT_HIGH, 16'd3000, high time in cycles loaded at reset (before clamping).

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable; 0 holds the divider idle.
- div_in  input  WIDTH  requested period minus one.
- high_in  input  WIDTH  requested high time in cycles.
- load  input  1  single-cycle request to capture div_in/high_in.
- load_ack  output  1  one-cycle pulse when the captured values take effect.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse coincident with each rising edge of clk_out.

Behaviour:
- Reset (async, rst_n=0):
  - cnt=0, running=0, clk_out=0, tick=0, load_ack=0, pending=0.
  - div_act=DEFAULT_DIV; high_act=DEFAULT_HIGH, clamped.
- Clamp rules, applied when values are captured into div_act/high_act:
  - div value 0 is treated as 1 (minimum period 2).
  - high 0 is treated as 1.
  - high >= div_act+1 is treated as div_act (output is never constantly high).
  - All arithmetic is WIDTH bits with no overflow: maximum period 2^WIDTH.
- Load:
  - load=1 captures div_in/high_in into pending registers and sets pending.
  - A load while pending=1 overwrites the pending values; only one load_ack results.
  - Apply point: the cycle in which cnt_next==0 (wrap, or start from idle). When running=0 and en=0, apply on the next clock edge.
  - load_ack is registered high for exactly the cycle after the apply edge; pending clears on the same edge.
- States: IDLE (running=0) and RUN (running=1).
- IDLE:
  - cnt=0, clk_out=0, tick=0.
  - On an edge with en=1: cnt<=0, clk_out<=1, tick<=1, running<=1. Latency from en sampled high to clk_out high is 1 cycle.
- RUN, on an edge with en=1:
  - cnt_next = (cnt==div_act) ? 0 : cnt+1.
  - clk_out <= (cnt_next < high_act).
  - tick <= (cnt_next==0).
  - Pending values are applied when cnt_next==0, so the new period starts from cnt=0 with the new values. A period never mixes old and new values.
- RUN, on an edge with en=0: go to IDLE. cnt<=0, clk_out<=0, tick<=0. The partial period is abandoned with no runt high pulse extension.
- Steady state: period = div_act+1 cycles; high for high_act cycles, then low for div_act+1-high_act cycles.
- Simultaneous events:
  - load and wrap in the same cycle: the new values are captured this edge and applied at the next wrap, not the current one.
  - en falling and load in the same cycle: the values are captured, then applied on the next idle edge.
- Reset mid-operation forces the reset values immediately, regardless of clock.

Test Plan:
- Reset, then load div=3 high=2 with en=0, then en=1 -> load_ack one cycle after load; clk_out 1,1,0,0 repeating from the cycle after en; tick at cycle offsets 0,4,8.
- div=3 high=7, then high=0 -> clamped patterns 1,1,1,0 and 1,0,0,0; never constant high.
- Running at div=3 high=2; load div=5 high=3 at cnt=1 -> old period completes (4 cycles); load_ack coincides with the first cycle of 1,1,1,0,0,0; no short or long pulse at the boundary.
- Two loads 1 cycle apart mid-period (div=7, then div=2 high=1) -> single load_ack; next period is 1,0,0.
- en dropped while clk_out=1 at cnt=1 -> clk_out=0 on the next cycle; en reasserted -> clk_out=1 and tick=1 one cycle later, with cnt restarting at 0.
- rst_n pulsed low between clock edges while running -> clk_out, tick and load_ack go 0 immediately; after release with en=1, period is DEFAULT_DIV+1=6000 cycles and high time is 3000 cycles.
